// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the burst memory controller.
package mem_ctrl_pkg;

  localparam int unsigned DEF_ADDRBITS = 32;
  localparam int unsigned DEF_DATABITS = 32;
  localparam int unsigned DEF_MEMWORDS = 1024;
  localparam int unsigned DEF_LATENCY  = 4;

  localparam int unsigned BURST_W = 16;
  localparam int unsigned WAIT_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RBURST,
    WBURST,
    DONE
  } state_e;

endpackage

// File: rtl/mem_ctrl_ram.sv
// Single-port synchronous backing store, one-cycle registered read, no reset on contents.
module mem_ctrl_ram
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATABITS = DEF_DATABITS,
  parameter int unsigned MEMWORDS = DEF_MEMWORDS
) (
  input  logic                        clk,
  input  logic                        we_i,
  input  logic [$clog2(MEMWORDS)-1:0] addr_i,
  input  logic [DATABITS-1:0]         wdata_i,
  output logic [DATABITS-1:0]         rdata_o
);

  logic [DATABITS-1:0] mem_q [MEMWORDS];
  logic [DATABITS-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// Burst memory controller: fixed-latency read/write bursts over a single-port RAM.
// Optional MEM_CTRL_ABORT_EN: dropping both requests before the burst ends returns to IDLE.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDRBITS = DEF_ADDRBITS,
  parameter int unsigned DATABITS = DEF_DATABITS,
  parameter int unsigned MEMWORDS = DEF_MEMWORDS,
  parameter int unsigned LATENCY  = DEF_LATENCY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDRBITS-1:0] mem_addr,
  input  logic [DATABITS-1:0] mem_in,
  input  logic                mem_rdreq,
  input  logic                mem_wrreq,
  input  logic [BURST_W-1:0]  mem_burstlen,
  output logic [DATABITS-1:0] mem_out,
  output logic                mem_valid
);

  localparam int unsigned       IDX_W     = $clog2(MEMWORDS);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LATENCY - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BURST_W-1:0]   len_q, len_d;
  logic [BURST_W-1:0]   beat_q, beat_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 is_wr_q, is_wr_d;
  logic                 valid_q, valid_d;
  logic [DATABITS-1:0]  out_q, out_d;

  logic                 ram_we_c;
  logic [IDX_W-1:0]     ram_addr_c;
  logic [DATABITS-1:0]  ram_rdata;
  logic                 unused_addr_c;

  assign unused_addr_c = ^{mem_addr[ADDRBITS-1:IDX_W+2], mem_addr[1:0]};

  mem_ctrl_ram #(
    .DATABITS (DATABITS),
    .MEMWORDS (MEMWORDS)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we_c),
    .addr_i  (ram_addr_c),
    .wdata_i (mem_in),
    .rdata_o (ram_rdata)
  );

  // Reads run two words ahead of the beat: one cycle for the RAM, one for the output register.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    is_wr_d    = is_wr_q;
    valid_d    = 1'b0;
    out_d      = out_q;
    ram_we_c   = 1'b0;
    ram_addr_c = idx_q + IDX_W'(2);

    case (state_q)
      IDLE: begin
        if (mem_rdreq || mem_wrreq) begin
          state_d = WAIT;
          idx_d   = mem_addr[IDX_W+1:2];
          len_d   = (mem_burstlen == '0) ? BURST_W'(1) : mem_burstlen;
          is_wr_d = mem_wrreq;
          wait_d  = '0;
          beat_d  = '0;
        end
      end
      WAIT: begin
        ram_addr_c = (wait_q == WAIT_LAST) ? idx_q + IDX_W'(1) : idx_q;
        if (wait_q == WAIT_LAST) begin
          state_d = is_wr_q ? WBURST : RBURST;
          valid_d = 1'b1;
          if (!is_wr_q) begin
            out_d = ram_rdata;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      RBURST, WBURST: begin
        if (state_q == WBURST) begin
          ram_we_c   = 1'b1;
          ram_addr_c = idx_q;
        end
        idx_d = idx_q + IDX_W'(1);
        if (beat_q == len_q - BURST_W'(1)) begin
          state_d = DONE;
        end else begin
          beat_d  = beat_q + BURST_W'(1);
          valid_d = 1'b1;
          if (state_q == RBURST) begin
            out_d = ram_rdata;
          end
        end
      end
      DONE: begin
        if (!mem_rdreq && !mem_wrreq) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef MEM_CTRL_ABORT_EN
    // The beat in flight still commits; no further beats are issued.
    if ((state_q == WAIT || state_q == RBURST || state_q == WBURST) &&
        !mem_rdreq && !mem_wrreq) begin
      state_d = IDLE;
      valid_d = 1'b0;
      out_d   = out_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      is_wr_q <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      is_wr_q <= is_wr_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign mem_out   = out_q;
  assign mem_valid = valid_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: cycle-scheduled beat model plus directed literal checks.
module tb_mem_ctrl;

  localparam int LAT = 4;
  localparam int MW  = 1024;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_in;
  logic        mem_rdreq;
  logic        mem_wrreq;
  logic [15:0] mem_burstlen;
  logic [31:0] mem_out;
  logic        mem_valid;

  mem_ctrl #(
    .ADDRBITS (32),
    .DATABITS (32),
    .MEMWORDS (MW),
    .LATENCY  (LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_addr     (mem_addr),
    .mem_in       (mem_in),
    .mem_rdreq    (mem_rdreq),
    .mem_wrreq    (mem_wrreq),
    .mem_burstlen (mem_burstlen),
    .mem_out      (mem_out),
    .mem_valid    (mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en   = 1'b0;
  logic [31:0] model [MW];
  logic [31:0] exp_d [int];
  bit          exp_rd [int];
  logic [31:0] wq [$];
  logic [31:0] seen_d [$];
  int          seen_c [$];
  int          last_e0;
  logic [31:0] hold_exp = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    int r;
    mem_addr     = $urandom;
    mem_burstlen = 16'($urandom);
    mem_in       = $urandom;
    r            = $urandom_range(0, 2);
    mem_rdreq    = (r != 1);
    mem_wrreq    = (r != 0);
  endtask

  // Every cycle: a scheduled beat must appear with its data, otherwise mem_valid low and mem_out held.
  always @(negedge clk) begin
    if (chk_en) begin
      if (mem_valid) begin
        seen_d.push_back(mem_out);
        seen_c.push_back(cyc);
      end
      if (exp_d.exists(cyc)) begin
        check("beat_valid", 64'(mem_valid), 64'd1);
        if (exp_rd[cyc]) begin
          check("beat_data", 64'(mem_out), 64'(exp_d[cyc]));
          hold_exp = exp_d[cyc];
        end else begin
          check("out_hold_wr", 64'(mem_out), 64'(hold_exp));
        end
      end else begin
        check("idle_valid", 64'(mem_valid), 64'd0);
        check("out_hold", 64'(mem_out), 64'(hold_exp));
      end
    end
  end

  task automatic do_reset(input int from_c, input int to_c);
    for (int c = from_c; c < to_c; c++) begin
      exp_d.delete(c);
      exp_rd.delete(c);
    end
    reset = 1'b1;
    #1;
    check("rst_valid_now", 64'(mem_valid), 64'd0);
    check("rst_out_now", 64'(mem_out), 64'd0);
    hold_exp  = 32'h0;
    mem_rdreq = 1'b0;
    mem_wrreq = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Beat k of a burst sampled at edge e0 occupies the cycle starting at edge e0+LAT+k.
  task automatic run_burst(input bit wr, input bit both, input logic [31:0] addr,
                           input logic [15:0] blen, input int hold, input int rst_beat);
    int          eff;
    int          e0;
    int          k;
    int          idx [];
    logic [31:0] wd [];
    eff = (blen == 16'd0) ? 1 : int'(blen);
    idx = new[eff];
    wd  = new[eff];
    seen_d.delete();
    seen_c.delete();
    mem_addr     = addr;
    mem_burstlen = blen;
    mem_wrreq    = wr | both;
    mem_rdreq    = ~wr | both;
    tick();
    e0      = cyc;
    last_e0 = e0;
    for (int j = 0; j < eff; j++) begin
      idx[j] = (int'(addr[11:2]) + j) % MW;
      wd[j]  = (wq.size() != 0) ? wq.pop_front() : $urandom;
      exp_d[e0 + LAT + j]  = wr ? wd[j] : model[idx[j]];
      exp_rd[e0 + LAT + j] = !wr;
    end
    while (cyc < e0 + LAT + eff) begin
      k = cyc - (e0 + LAT);
      scramble();
      if (k >= 0 && k == rst_beat) begin
        do_reset(cyc, e0 + LAT + eff);
        return;
      end
      if (wr && k >= 0) mem_in = wd[k];
      tick();
      if (wr && k >= 0) model[idx[k]] = wd[k];
    end
    for (int h = 0; h < hold; h++) begin
      scramble();
      tick();
    end
    mem_rdreq = 1'b0;
    mem_wrreq = 1'b0;
    mem_addr  = $urandom;
    tick();
  endtask

  task automatic abort_test();
    int e0;
    seen_d.delete();
    seen_c.delete();
    mem_addr     = 32'h400;
    mem_burstlen = 16'd8;
    mem_rdreq    = 1'b1;
    mem_wrreq    = 1'b0;
    tick();
    e0        = cyc;
    mem_rdreq = 1'b0;
`ifndef MEM_CTRL_ABORT_EN
    for (int j = 0; j < 8; j++) begin
      exp_d[e0 + LAT + j]  = model[(256 + j) % MW];
      exp_rd[e0 + LAT + j] = 1'b1;
    end
`endif
    repeat (LAT + 12) tick();
`ifdef MEM_CTRL_ABORT_EN
    check("abort_beats", 64'(seen_d.size()), 64'd0);
`else
    check("noabort_beats", 64'(seen_d.size()), 64'd8);
`endif
  endtask

  initial begin
    reset        = 1'b1;
    mem_addr     = 32'h0;
    mem_in       = 32'h0;
    mem_rdreq    = 1'b0;
    mem_wrreq    = 1'b0;
    mem_burstlen = 16'h0;
    tick();
    tick();
    check("reset_valid", 64'(mem_valid), 64'd0);
    check("reset_out", 64'(mem_out), 64'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Fill the whole store so every later read has a defined expectation.
    run_burst(1'b1, 1'b0, 32'h0, 16'd1024, 0, -1);

    // Single write then read.
    wq.push_back(32'hDEADBEEF);
    run_burst(1'b1, 1'b0, 32'h10, 16'd1, 0, -1);
    run_burst(1'b0, 1'b0, 32'h10, 16'd1, 0, -1);
    check("single_n", 64'(seen_d.size()), 64'd1);
    if (seen_d.size() >= 1) begin
      check("single_lat", 64'(seen_c[0] - last_e0), 64'd4);
      check("single_data", 64'(seen_d[0]), 64'hDEADBEEF);
    end

    // Burst wrapping from index 1023 to 0.
    for (int j = 1; j <= 4; j++) wq.push_back(32'(j));
    run_burst(1'b1, 1'b0, 32'hFF8, 16'd4, 0, -1);
    run_burst(1'b0, 1'b0, 32'hFF8, 16'd4, 0, -1);
    check("wrap_n", 64'(seen_d.size()), 64'd4);
    for (int j = 0; j < 4 && j < seen_d.size(); j++) begin
      check("wrap_data", 64'(seen_d[j]), 64'(j + 1));
      check("wrap_cycle", 64'(seen_c[j] - last_e0), 64'(4 + j));
    end
    run_burst(1'b0, 1'b0, 32'h0, 16'd2, 0, -1);
    check("wrap_idx_n", 64'(seen_d.size()), 64'd2);
    if (seen_d.size() >= 2) begin
      check("wrap_idx0", 64'(seen_d[0]), 64'd3);
      check("wrap_idx1", 64'(seen_d[1]), 64'd4);
    end

    // Burstlen 0 with both requests high acts as a one-word write.
    wq.push_back(32'h55);
    run_burst(1'b1, 1'b1, 32'h200, 16'd0, 0, -1);
    check("len0_n", 64'(seen_d.size()), 64'd1);
    run_burst(1'b0, 1'b0, 32'h200, 16'd1, 0, -1);
    if (seen_d.size() >= 1) check("len0_data", 64'(seen_d[0]), 64'h55);

    // Request held in DONE produces nothing; a one-cycle drop rearms.
    run_burst(1'b0, 1'b0, 32'h10, 16'd2, 5, -1);
    check("done_hold_n", 64'(seen_d.size()), 64'd2);
    run_burst(1'b0, 1'b0, 32'hFF8, 16'd1, 0, -1);
    check("rearm_n", 64'(seen_d.size()), 64'd1);
    if (seen_d.size() >= 1) begin
      check("rearm_lat", 64'(seen_c[0] - last_e0), 64'd4);
      check("rearm_data", 64'(seen_d[0]), 64'd1);
    end

    // Reset during beat 2 of a read, then re-read the same words.
    run_burst(1'b0, 1'b0, 32'hFF8, 16'd4, 0, 1);
    check("rst_rd_n", 64'(seen_d.size()), 64'd1);
    run_burst(1'b0, 1'b0, 32'hFF8, 16'd4, 0, -1);
    for (int j = 0; j < 4 && j < seen_d.size(); j++)
      check("rst_rd_data", 64'(seen_d[j]), 64'(j + 1));

    // Reset during beat 2 of a write: only beat 1 lands.
    for (int j = 0; j < 4; j++) wq.push_back(32'hA0 + 32'(j));
    run_burst(1'b1, 1'b0, 32'h300, 16'd4, 0, 1);
    run_burst(1'b0, 1'b0, 32'h300, 16'd4, 0, -1);
    if (seen_d.size() >= 1) check("rst_wr_first", 64'(seen_d[0]), 64'hA0);

    abort_test();
    run_burst(1'b0, 1'b0, 32'h10, 16'd1, 0, -1);
    if (seen_d.size() >= 1) check("post_abort", 64'(seen_d[0]), 64'hDEADBEEF);

    for (int i = 0; i < 40; i++) begin
      bit          wr;
      bit          both;
      logic [15:0] blen;
      int          rb;
      wr   = 1'($urandom_range(0, 1));
      both = wr & 1'($urandom_range(0, 1));
      blen = 16'($urandom_range(0, 24));
      rb   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, (blen == 16'd0) ? 0 : int'(blen) - 1) : -1;
      run_burst(wr, both, $urandom, blen, $urandom_range(0, 3), rb);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDRBITS, default 32, meaning request address width.
REQ-002 The block SHALL have parameter DATABITS, default 32, meaning data word width.
REQ-003 The block SHALL have parameter MEMWORDS, default 1024 (power of two), meaning backing-store depth in words.
REQ-004 The block SHALL have parameter LATENCY, default 4 (legal range 2..255), meaning cycles from request sample to first beat.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port mem_addr, input, ADDRBITS: byte address of the first beat.
REQ-008 The block SHALL have port mem_in, input, DATABITS: write data.
REQ-009 The block SHALL have port mem_rdreq, input, 1 bit: read request level.
REQ-010 The block SHALL have port mem_wrreq, input, 1 bit: write request level.
REQ-011 The block SHALL have port mem_burstlen, input, 16 bits: number of words in the burst.
REQ-012 The block SHALL have port mem_out, output, DATABITS: read data.
REQ-013 The block SHALL have port mem_valid, output, 1 bit: beat strobe for both reads and writes.

Function
REQ-014 The state machine SHALL have states IDLE, WAIT, RBURST, WBURST and DONE.
REQ-015 In IDLE with mem_rdreq or mem_wrreq high, the block SHALL capture mem_addr, mem_burstlen and the direction on the edge (edge E0) and go to WAIT.
REQ-016 When mem_rdreq and mem_wrreq are both high in IDLE, the request SHALL be handled as a write.
REQ-017 A captured mem_burstlen of 0 SHALL be handled as 1.
REQ-018 The word index SHALL be mem_addr[log2(MEMWORDS)+1:2]; address bits [1:0] SHALL be ignored, and upper bits SHALL alias.
REQ-019 WAIT SHALL count LATENCY-1 cycles; the first beat SHALL have mem_valid high in the cycle starting LATENCY edges after E0.
REQ-020 In RBURST, the block SHALL drive mem_out with RAM[index] and assert mem_valid for exactly one cycle per word, on consecutive cycles with no gaps.
REQ-021 In WBURST, the block SHALL write mem_in to RAM[index] on each edge that ends a cycle with mem_valid high; the requester SHALL present the next word in the cycle after each mem_valid.
REQ-022 After each beat, index SHALL increment modulo MEMWORDS (wrap from MEMWORDS-1 to 0); the beat counter SHALL be 16 bits.
REQ-023 After the last beat, the block SHALL go to DONE with mem_valid low, and SHALL remain in DONE until mem_rdreq and mem_wrreq are both low, then go to IDLE.
REQ-024 While the block is not in IDLE, changes on mem_addr, mem_burstlen or the request direction SHALL be ignored.
REQ-025 When not in RBURST, mem_out SHALL hold its last value; mem_out SHALL be valid only while mem_valid is high.
REQ-026 mem_valid SHALL be low in IDLE, WAIT and DONE.

Reset
REQ-027 Asserting reset SHALL immediately force state IDLE, mem_valid 0, mem_out 0 and all counters 0, including mid-burst.
REQ-028 Reset SHALL NOT clear RAM contents; a write beat in progress when reset asserts SHALL NOT be committed.
REQ-029 After reset deasserts, a request that is held high SHALL be sampled on the first edge.

Configuration
REQ-030 With macro MEM_CTRL_ABORT_EN defined, deassertion of both mem_rdreq and mem_wrreq in WAIT, RBURST or WBURST SHALL abort to IDLE on the next edge, and the remaining beats SHALL not be performed.
REQ-031 With MEM_CTRL_ABORT_EN undefined, a sampled burst SHALL always complete in full regardless of the request levels.

Structure
REQ-032 Package mem_ctrl_pkg SHALL hold the state enum, the default width constants and the burst-counter width (16).
REQ-033 The backing store SHALL be a sub-module mem_ctrl_ram: single-port synchronous RAM, MEMWORDS x DATABITS, one-cycle read latency.

Verification
REQ-034 The bench SHALL cover a single write then read: write 0xDEADBEEF at 0x10 with burstlen 1, then read 0x10 with burstlen 1 -> mem_valid at E0+4, and mem_out = 0xDEADBEEF.
REQ-035 The bench SHALL cover a burst with wrap: write 4 words 1,2,3,4 at byte address 0xFF8 (MEMWORDS=1024), then read 4 words at 0xFF8 -> 1,2,3,4 on consecutive cycles, with words 3 and 4 stored at indices 0 and 1.
REQ-036 The bench SHALL cover burstlen 0 and simultaneous requests: rdreq=wrreq=1, burstlen 0, mem_in 0x55 -> exactly one mem_valid, then a read returns 0x55.
REQ-037 The bench SHALL cover DONE hold: the request is held high after the last beat for 5 cycles -> no new mem_valid; after deassert for 1 cycle and reassert, a new burst starts.
REQ-038 The bench SHALL cover reset mid-burst: reset asserted during beat 2 of a 4-word read -> mem_valid 0 immediately; afterwards a read of the same words returns the prior contents.
REQ-039 The bench SHALL cover abort: with MEM_CTRL_ABORT_EN, rdreq dropped during WAIT of an 8-word read -> no mem_valid and state IDLE; without the macro, 8 beats SHALL occur.
